// File: rtl/polaris_bus_arbiter.sv
// Two-master round-robin arbiter sharing one 64-bit memory bus between the
// instruction-fetch (I) and data load/store (D) ports, with a timeout watchdog.
module polaris_bus_arbiter #(
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        istb_i,
    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    output logic        ierr_o,
    input  logic        dstb_i,
    input  logic        dwe_i,
    input  logic [63:0] dadr_i,
    input  logic [1:0]  dsiz_i,
    input  logic [63:0] ddat_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic        derr_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [63:0] adr_o,
    output logic [1:0]  siz_o,
    output logic [63:0] dat_o,
    input  logic        ack_i,
    input  logic [63:0] dat_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } state_t;

    localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT);

    state_t        r_state;
    state_t        w_nextState;
    logic          r_lastD;
    logic [TW-1:0] r_cnt;
    logic          w_busy;
    logic          w_expire;
    logic          w_done;

    assign w_busy   = (r_state != ST_IDLE);
    // Ack in the expiry cycle takes priority over the timeout abort.
    assign w_expire = w_busy && !ack_i && (r_cnt == LP_TIMEOUT);
    assign w_done   = w_busy && (ack_i || w_expire);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_lastD <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_done) begin
                r_lastD <= (r_state == ST_DBUS);
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (istb_i && dstb_i) begin
                    w_nextState = r_lastD ? ST_IBUS : ST_DBUS;
                end else if (istb_i) begin
                    w_nextState = ST_IBUS;
                end else if (dstb_i) begin
                    w_nextState = ST_DBUS;
                end
            end
            ST_IBUS, ST_DBUS: begin
                if (w_done) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        stb_o  = 1'b0;
        we_o   = 1'b0;
        adr_o  = '0;
        siz_o  = '0;
        dat_o  = '0;
        iack_o = 1'b0;
        idat_o = '0;
        ierr_o = 1'b0;
        dack_o = 1'b0;
        ddat_o = '0;
        derr_o = 1'b0;
        case (r_state)
            ST_IBUS: begin
                stb_o  = 1'b1;
                adr_o  = iadr_i;
                siz_o  = isiz_i;
                iack_o = ack_i;
                ierr_o = w_expire;
                if (ack_i) begin
                    idat_o = iadr_i[2] ? dat_i[63:32] : dat_i[31:0];
                end
            end
            ST_DBUS: begin
                stb_o  = 1'b1;
                we_o   = dwe_i;
                adr_o  = dadr_i;
                siz_o  = dsiz_i;
                dat_o  = ddat_i;
                dack_o = ack_i;
                derr_o = w_expire;
                if (ack_i) begin
                    ddat_o = dat_i;
                end
            end
            default: ;
        endcase
    end

    assign gnt_o = {r_state == ST_DBUS, r_state == ST_IBUS};

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_polaris_bus_arbiter;

    localparam int TW      = 8;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        resetI;
    logic        istbI, dstbI, dweI, ackI;
    logic [63:0] iadrI, dadrI, ddatI, datI;
    logic [1:0]  isizI, dsizI;
    logic        iackO, ierrO, dackO, derrO, stbO, weO;
    logic [31:0] idatO;
    logic [63:0] ddatO, adrO, datO;
    logic [1:0]  sizO, gntO;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the bus, how long it has waited, who went last.
    int modelOwner;
    int modelElapsed;
    bit modelLastD;
    logic        expStb, expWe, expIack, expIerr, expDack, expDerr;
    logic [63:0] expAdr, expDat, expDdat;
    logic [1:0]  expSiz, expGnt;
    logic [31:0] expIdat;

    polaris_bus_arbiter #(.TW(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(resetI),
        .istb_i(istbI), .iadr_i(iadrI), .isiz_i(isizI),
        .iack_o(iackO), .idat_o(idatO), .ierr_o(ierrO),
        .dstb_i(dstbI), .dwe_i(dweI), .dadr_i(dadrI), .dsiz_i(dsizI), .ddat_i(ddatI),
        .dack_o(dackO), .ddat_o(ddatO), .derr_o(derrO),
        .stb_o(stbO), .we_o(weO), .adr_o(adrO), .siz_o(sizO), .dat_o(datO),
        .ack_i(ackI), .dat_i(datI), .gnt_o(gntO)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        modelOwner   = 0;
        modelElapsed = 0;
        modelLastD   = 1'b1;
    endtask

    task automatic modelStep();
        if (modelOwner == 0) begin
            if (istbI && dstbI) modelOwner = modelLastD ? 1 : 2;
            else if (istbI)     modelOwner = 1;
            else if (dstbI)     modelOwner = 2;
        end else if (ackI || modelElapsed == TIMEOUT) begin
            modelLastD   = (modelOwner == 2);
            modelOwner   = 0;
            modelElapsed = 0;
        end else begin
            modelElapsed++;
        end
    endtask

    task automatic modelOutputs();
        expStb = 0; expWe = 0; expAdr = '0; expSiz = '0; expDat = '0;
        expIack = 0; expIdat = '0; expIerr = 0; expDack = 0; expDdat = '0; expDerr = 0;
        expGnt = 2'b00;
        if (modelOwner == 1) begin
            expStb = 1; expAdr = iadrI; expSiz = isizI; expGnt = 2'b01;
            expIack = ackI;
            expIerr = !ackI && (modelElapsed == TIMEOUT);
            if (ackI) expIdat = iadrI[2] ? datI[63:32] : datI[31:0];
        end else if (modelOwner == 2) begin
            expStb = 1; expWe = dweI; expAdr = dadrI; expSiz = dsizI; expDat = ddatI;
            expGnt = 2'b10;
            expDack = ackI;
            expDerr = !ackI && (modelElapsed == TIMEOUT);
            if (ackI) expDdat = datI;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetI) modelReset();
        else        modelStep();
        #1;
    endtask

    task automatic resetDut();
        resetI = 1'b1;
        modelReset();
        tick();
        resetI = 1'b0;
    endtask

    task automatic clearInputs();
        istbI = 0; dstbI = 0; dweI = 0; ackI = 0;
        iadrI = '0; dadrI = '0; ddatI = '0; datI = '0;
        isizI = '0; dsizI = '0;
    endtask

    task automatic test_reset();
        clearInputs();
        resetI = 1'b1;
        modelReset();
        tick();
        tick();
        vectors++;
        if ({stbO, weO, gntO, iackO, dackO, ierrO, derrO} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b want 00000000",
                     {stbO, weO, gntO, iackO, dackO, ierrO, derrO});
        end
        resetI = 1'b0;
        ackI = 1'b1;
        datI = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        vectors++;
        if ({iackO, dackO, idatO, ddatO} !== '0) begin
            miscompares++;
            $display("[TB] FAIL idle_ack_ignored: iack=%b dack=%b idat=%h ddat=%h want all 0",
                     iackO, dackO, idatO, ddatO);
        end
        ackI = 1'b0;
    endtask

    task automatic test_single_fetch();
        istbI = 1'b1;
        iadrI = 64'hFFFF_FFFF_FFFF_FF00;
        isizI = 2'b10;
        #1;
        vectors++;
        if (stbO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fetch_no_comb_grant: stb=%b want 0", stbO);
        end
        tick();
        vectors++;
        if ({stbO, weO, gntO, iackO} !== 5'b10010 || adrO !== iadrI || sizO !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL fetch_grant: stb=%b we=%b gnt=%b iack=%b adr=%h siz=%b want 1 0 01 0 %h 10",
                     stbO, weO, gntO, iackO, adrO, sizO, iadrI);
        end
        ackI = 1'b1;
        datI = 64'h1111_2222_3333_4444;
        #1;
        vectors++;
        if (iackO !== 1'b1 || idatO !== 32'h3333_4444) begin
            miscompares++;
            $display("[TB] FAIL fetch_ack: iack=%b idat=%h want 1 33334444", iackO, idatO);
        end
        tick();
        istbI = 1'b0;
        ackI = 1'b0;
        #1;
        vectors++;
        if ({stbO, gntO, iackO} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL fetch_back_idle: stb=%b gnt=%b iack=%b want 0 00 0", stbO, gntO, iackO);
        end
    endtask

    task automatic test_d_write();
        dstbI = 1'b1;
        dweI  = 1'b1;
        dadrI = 64'h100;
        ddatI = 64'hDEAD_BEEF_0BAD_F00D;
        dsizI = 2'b11;
        tick();
        vectors++;
        if ({stbO, weO, gntO, dackO} !== 5'b11100 || adrO !== 64'h100 ||
            datO !== 64'hDEAD_BEEF_0BAD_F00D || sizO !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL dwrite_bus: stb=%b we=%b gnt=%b dack=%b adr=%h dat=%h siz=%b",
                     stbO, weO, gntO, dackO, adrO, datO, sizO);
        end
        ackI = 1'b1;
        datI = {$urandom, $urandom};
        #1;
        vectors++;
        if (dackO !== 1'b1 || iackO !== 1'b0 || ddatO !== datI) begin
            miscompares++;
            $display("[TB] FAIL dwrite_ack: dack=%b iack=%b ddat=%h want 1 0 %h", dackO, iackO, ddatO, datI);
        end
        tick();
        dstbI = 1'b0;
        dweI  = 1'b0;
        ackI  = 1'b0;
    endtask

    task automatic test_alternation();
        logic [1:0] expSeq [8];
        expSeq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        resetDut();
        istbI = 1'b1;
        dstbI = 1'b1;
        iadrI = 64'h2000;
        dadrI = 64'h3000;
        ackI  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (gntO !== expSeq[k]) begin
                miscompares++;
                $display("[TB] FAIL alternate_gnt[%0d]: got %b want %b", k, gntO, expSeq[k]);
            end
        end
        istbI = 1'b0;
        dstbI = 1'b0;
        ackI  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int stbCycles = 0;
        int ierrs = 0;
        int errCycle = 0;
        int iacks = 0;
        int guard = 0;
        istbI = 1'b1;
        iadrI = 64'h4000;
        ackI  = 1'b0;
        tick();
        dstbI = 1'b1;
        dweI  = 1'b0;
        dadrI = 64'h5008;
        while (gntO == 2'b01 && guard < 20) begin
            if (stbO) stbCycles++;
            if (iackO) iacks++;
            if (ierrO) begin
                ierrs++;
                errCycle = stbCycles;
                istbI = 1'b0;
            end
            tick();
            guard++;
        end
        istbI = 1'b0;
        vectors++;
        if (stbCycles != TIMEOUT + 1 || ierrs != 1 || errCycle != TIMEOUT + 1 || iacks != 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_abort: stbCycles=%0d ierrs=%0d errCycle=%0d iacks=%0d want %0d 1 %0d 0",
                     stbCycles, ierrs, errCycle, iacks, TIMEOUT + 1, TIMEOUT + 1);
        end
        vectors++;
        if ({stbO, gntO} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL timeout_idle: stb=%b gnt=%b want 0 00", stbO, gntO);
        end
        tick();
        vectors++;
        if (gntO !== 2'b10 || adrO !== 64'h5008) begin
            miscompares++;
            $display("[TB] FAIL timeout_pending_d: gnt=%b adr=%h want 10 5008", gntO, adrO);
        end
        ackI = 1'b1;
        tick();
        dstbI = 1'b0;
        ackI  = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        dstbI = 1'b1;
        dweI  = 1'b0;
        dadrI = 64'h6000;
        ackI  = 1'b0;
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            vectors++;
            if ({gntO, dackO, derrO} !== 4'b1000) begin
                miscompares++;
                $display("[TB] FAIL ack_timeout_wait[%0d]: gnt=%b dack=%b derr=%b want 10 0 0",
                         k, gntO, dackO, derrO);
            end
            tick();
        end
        ackI = 1'b1;
        datI = 64'h0123_4567_89AB_CDEF;
        #1;
        vectors++;
        if (dackO !== 1'b1 || derrO !== 1'b0 || ddatO !== 64'h0123_4567_89AB_CDEF) begin
            miscompares++;
            $display("[TB] FAIL ack_wins_timeout: dack=%b derr=%b ddat=%h want 1 0 0123456789abcdef",
                     dackO, derrO, ddatO);
        end
        tick();
        dstbI = 1'b0;
        ackI  = 1'b0;
    endtask

    task automatic test_async_reset();
        dstbI = 1'b1;
        dweI  = 1'b1;
        dadrI = 64'h7000;
        ackI  = 1'b0;
        tick();
        #1;
        vectors++;
        if ({stbO, weO, gntO} !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL async_pre: stb=%b we=%b gnt=%b want 1 1 10", stbO, weO, gntO);
        end
        #1;
        resetI = 1'b1;
        modelReset();
        #1;
        vectors++;
        if ({stbO, weO, gntO, dackO, derrO} !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL async_drop: stb=%b we=%b gnt=%b dack=%b derr=%b want all 0",
                     stbO, weO, gntO, dackO, derrO);
        end
        istbI = 1'b1;
        iadrI = 64'h7100;
        dweI  = 1'b0;
        resetI = 1'b0;
        tick();
        vectors++;
        if (gntO !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL async_first_tie: gnt=%b want 01", gntO);
        end
        ackI = 1'b1;
        tick();
        istbI = 1'b0;
        tick();
        dstbI = 1'b0;
        ackI  = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit iDone = 0;
        bit dDone = 0;
        resetDut();
        clearInputs();
        for (int n = 0; n < 400; n++) begin
            if (iDone) istbI = 1'b0;
            if (dDone) dstbI = 1'b0;
            if (!istbI && $urandom_range(0, 2) == 0) begin
                istbI = 1'b1;
                iadrI = {$urandom, $urandom};
                isizI = 2'($urandom);
            end
            if (!dstbI && $urandom_range(0, 2) == 0) begin
                dstbI = 1'b1;
                dweI  = 1'($urandom);
                dadrI = {$urandom, $urandom};
                dsizI = 2'($urandom);
                ddatI = {$urandom, $urandom};
            end
            ackI = ($urandom_range(0, 2) == 0);
            datI = {$urandom, $urandom};
            modelOutputs();
            #1;
            vectors++;
            if ({stbO, weO, gntO, iackO, ierrO, dackO, derrO} !== {expStb, expWe, expGnt, expIack, expIerr, expDack, expDerr}) begin
                miscompares++;
                $display("[TB] FAIL rand_ctrl[%0d]: got %b want %b", n,
                         {stbO, weO, gntO, iackO, ierrO, dackO, derrO},
                         {expStb, expWe, expGnt, expIack, expIerr, expDack, expDerr});
            end
            vectors++;
            if (adrO !== expAdr || sizO !== expSiz || datO !== expDat) begin
                miscompares++;
                $display("[TB] FAIL rand_bus[%0d]: adr=%h siz=%b dat=%h want %h %b %h",
                         n, adrO, sizO, datO, expAdr, expSiz, expDat);
            end
            vectors++;
            if (idatO !== expIdat || ddatO !== expDdat) begin
                miscompares++;
                $display("[TB] FAIL rand_rdata[%0d]: idat=%h ddat=%h want %h %h",
                         n, idatO, ddatO, expIdat, expDdat);
            end
            iDone = expIack || expIerr;
            dDone = expDack || expDerr;
            tick();
        end
        clearInputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_d_write();
        test_alternation();
        test_timeout();
        test_ack_at_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/polaris_bus_arbiter.md
Name: polaris_bus_arbiter

Overview:
- Shares one external 64-bit memory bus between two masters: the PolarisCPU instruction-fetch port (I, read-only) and a data load/store port (D, read/write).
- Sits between the CPU core and the system bus.
- Provides round-robin grant, per-transfer grant hold until acknowledge, and a bus-timeout watchdog so a missing slave cannot jam the core.

Parameters:
- TIMEOUT, 255, maximum cycles a granted transfer waits for ack_i before it is aborted (1..2^TW-1).
- TW, 8, width of the timeout counter.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- istb_i  in  1  I request; held high until iack_o or ierr_o.
- iadr_i  in  64  I byte address.
- isiz_i  in  2  I transfer size (2'b10 = 32-bit word).
- iack_o  out  1  I transfer complete; idat_o valid this cycle.
- idat_o  out  32  I read data.
- ierr_o  out  1  I transfer aborted by timeout (1-cycle pulse).
- dstb_i  in  1  D request; held high until dack_o or derr_o.
- dwe_i  in  1  D write enable.
- dadr_i  in  64  D byte address.
- dsiz_i  in  2  D size (00 byte, 01 half, 10 word, 11 dword).
- ddat_i  in  64  D write data.
- dack_o  out  1  D transfer complete.
- ddat_o  out  64  D read data.
- derr_o  out  1  D timeout abort (1-cycle pulse).
- stb_o  out  1  bus strobe.
- we_o  out  1  bus write enable.
- adr_o  out  64  bus address.
- siz_o  out  2  bus size.
- dat_o  out  64  bus write data.
- ack_i  in  1  bus acknowledge.
- dat_i  in  64  bus read data.
- gnt_o  out  2  current grant: 01 = I, 10 = D, 00 = idle (diagnostic).

Behaviour:
- States: IDLE, IBUS, DBUS. Registered state; `last` register records the last master served (reset = D, so I wins the first tie).
- Reset (asynchronous): state = IDLE, last = D, timeout counter = 0. All outputs 0 immediately, including stb_o, acks, errs and gnt_o. A transfer in flight is dropped without ack or err.
- IDLE:
  - Only istb_i → IBUS.
  - Only dstb_i → DBUS.
  - Both → grant the master not equal to `last`.
  - Neither → stay in IDLE.
  - Bus outputs are 0 in IDLE. Requests are sampled at the edge only; no combinational grant.
- IBUS:
  - stb_o = 1, we_o = 0, adr_o = iadr_i, siz_o = isiz_i, dat_o = 0.
  - iack_o = ack_i (combinational).
  - idat_o = adr_o[2] ? dat_i[63:32] : dat_i[31:0].
- DBUS:
  - stb_o = 1, we_o = dwe_i, adr_o = dadr_i, siz_o = dsiz_i, dat_o = ddat_i.
  - dack_o = ack_i; ddat_o = dat_i.
- Data outputs idat_o and ddat_o are 0 whenever the matching ack is low.
- Completion: ack_i high in IBUS or DBUS → next state IDLE, `last` ← served master, counter ← 0.
- Throughput: minimum 2 cycles per transfer (grant cycle + ack cycle). Back-to-back requests from the same master alternate with any pending request from the other master.
- Timeout:
  - The counter increments each cycle in IBUS or DBUS without ack_i.
  - When counter == TIMEOUT with ack_i low: pulse ierr_o or derr_o (per grant) for that cycle, drop stb_o next cycle, go to IDLE, update `last`, clear the counter.
  - If ack_i arrives in the same cycle the counter reaches TIMEOUT, ack wins and no err pulse is produced.
- Requests dropped mid-grant are a protocol violation. The arbiter holds the grant regardless and continues to drive the dropped master's address lines.
- ack_i in IDLE is ignored; no ack is forwarded to either master.
- gnt_o = {state==DBUS, state==IBUS}.

Test Plan:
- Reset, then istb_i=1, iadr_i=64'hFFFF_FFFF_FFFF_FF00, slave acks on 2nd strobe cycle with dat_i=64'h1111_2222_3333_4444 → stb_o rises 1 cycle after request; iack_o pulses once with idat_o=32'h3333_4444; state returns to IDLE.
- istb_i and dstb_i asserted together and held continuously; slave acks every strobe cycle → grants alternate I, D, I, D; gnt_o sequence 01, 00, 10, 00, 01 …
- D write: dwe_i=1, dadr_i=64'h100, ddat_i=64'hDEAD_BEEF_0BAD_F00D, dsiz_i=2'b11 → bus shows we_o=1 with identical adr/dat/siz; dack_o mirrors ack_i; iack_o stays 0.
- No ack_i with TIMEOUT=4 → stb_o high for exactly 5 cycles; ierr_o pulses once in the 5th cycle; no iack_o; a pending dstb_i is granted next.
- Assert reset_i asynchronously mid-DBUS with ack pending → stb_o, we_o, gnt_o drop before the next clock edge; after release, the first tie is granted to I.
- ack_i arrives in the same cycle the counter reaches TIMEOUT → dack_o=1, derr_o=0.
